// File: rtl/tx_frame_packer.sv
// tx_frame_packer: gathers payload bytes into a frame buffer, then feeds the
// framed byte stream (header, type, length, payload, checksum, tail) to a
// byte-wide UART transmitter one byte at a time.
//
// Handshake with the UART: Tx_Start_Sig is a one-cycle pulse that marks
// Tx_Data as a new byte to send; Tx_Data is held until the next pulse.
// The UART answers with a one-cycle Tx_Done_Sig once the byte has left.
// Only a Tx_Done_Sig arriving in SEND while no start pulse is being issued
// advances the stream; the next Tx_Start_Sig follows exactly one cycle later.
module tx_frame_packer #(
    parameter int           MAX_LEN   = 16,
    parameter int           CSUM_MODE = 0,
    parameter logic [7:0]   HEAD0     = 8'hFF,
    parameter logic [7:0]   HEAD1     = 8'hFE,
    parameter logic [7:0]   TAIL0     = 8'hFE,
    parameter logic [7:0]   TAIL1     = 8'hFF
) (
    input  logic        CLOCK_50M,
    input  logic        RST,
    input  logic        Frame_Start_Sig,
    input  logic [7:0]  Frame_Type,
    input  logic        Data_Send_Sig,
    input  logic [7:0]  Data,
    input  logic        Frame_End_Sig,
    input  logic        Tx_Done_Sig,
    output logic        Tx_Start_Sig,
    output logic [7:0]  Tx_Data,
    output logic        Tx_En_Sig,
    output logic        Busy,
    output logic        Frame_Done_Sig,
    output logic        Err_Sig,
    output logic [1:0]  state_dbg
);

    // Buffer address width; a one-entry buffer still needs one address bit.
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_SEND    = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     type_reg, type_nxt;
    logic [7:0]     count, count_nxt;
    logic [15:0]    csum, csum_nxt, csum_upd;
    logic [8:0]     idx, idx_nxt;
    logic           tx_start_nxt;
    logic [7:0]     tx_data_nxt;
    logic           done_nxt;
    logic           err_nxt;
    logic           buf_we;
    logic           close;

    // Byte-selection helpers for the transmit stream.
    logic [8:0]     cnt9;
    logic [8:0]     sel_idx;
    logic [8:0]     last_idx;
    logic [AW-1:0]  data_off;
    logic [7:0]     csum_hi, csum_lo;
    logic [7:0]     byte_sel;

    logic [7:0]     frame_buf [MAX_LEN];

    assign Tx_En_Sig = (state == S_SEND);
    assign Busy      = (state != S_IDLE);
    assign state_dbg = state;

    assign cnt9     = {1'b0, count};
    assign sel_idx  = idx + 9'd1;
    assign last_idx = cnt9 + 9'd7;
    assign data_off = AW'(sel_idx - 9'd4);
    assign csum_hi  = (CSUM_MODE == 1) ? 8'h00 : csum[15:8];
    assign csum_lo  = csum[7:0];
    assign csum_upd = (CSUM_MODE == 1) ? (csum ^ {8'h00, Data})
                                       : (csum + {8'h00, Data});

    // Pick the byte that follows position idx in the frame layout.
    always_comb begin
        byte_sel = TAIL1;
        if (sel_idx == 9'd1) begin
            byte_sel = HEAD1;
        end else if (sel_idx == 9'd2) begin
            byte_sel = type_reg;
        end else if (sel_idx == 9'd3) begin
            byte_sel = count;
        end else if (sel_idx < cnt9 + 9'd4) begin
            byte_sel = frame_buf[data_off];
        end else if (sel_idx == cnt9 + 9'd4) begin
            byte_sel = csum_hi;
        end else if (sel_idx == cnt9 + 9'd5) begin
            byte_sel = csum_lo;
        end else if (sel_idx == cnt9 + 9'd6) begin
            byte_sel = TAIL0;
        end
    end

    // Next-state and next-output logic for the IDLE / COLLECT / SEND machine.
    always_comb begin
        state_nxt    = state;
        type_nxt     = type_reg;
        count_nxt    = count;
        csum_nxt     = csum;
        idx_nxt      = idx;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = Tx_Data;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        buf_we       = 1'b0;
        close        = 1'b0;
        case (state)
            S_IDLE: begin
                // A payload strobe or end pulse with no open frame is rejected.
                if (Data_Send_Sig || Frame_End_Sig) begin
                    err_nxt = 1'b1;
                end
                if (Frame_Start_Sig) begin
                    type_nxt  = Frame_Type;
                    count_nxt = 8'd0;
                    csum_nxt  = 16'd0;
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (Frame_Start_Sig) begin
                    // Restart: drop what was collected, keep collecting.
                    type_nxt  = Frame_Type;
                    count_nxt = 8'd0;
                    csum_nxt  = 16'd0;
                end else begin
                    // Store first so a coincident end pulse counts this byte.
                    if (Data_Send_Sig) begin
                        buf_we    = 1'b1;
                        count_nxt = count + 8'd1;
                        csum_nxt  = csum_upd;
                        if (cnt9 + 9'd1 == 9'(MAX_LEN)) begin
                            close = 1'b1;
                        end
                    end
                    if (Frame_End_Sig) begin
                        close = 1'b1;
                    end
                end
                if (close) begin
                    state_nxt    = S_SEND;
                    idx_nxt      = 9'd0;
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = HEAD0;
                end
            end
            S_SEND: begin
                if (Frame_Start_Sig || Data_Send_Sig || Frame_End_Sig) begin
                    err_nxt = 1'b1;
                end
                if (Tx_Done_Sig && !Tx_Start_Sig) begin
                    if (idx == last_idx) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        idx_nxt      = sel_idx;
                        tx_start_nxt = 1'b1;
                        tx_data_nxt  = byte_sel;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters, checksum and registered outputs.
    always_ff @(posedge CLOCK_50M or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            type_reg       <= 8'h00;
            count          <= 8'd0;
            csum           <= 16'd0;
            idx            <= 9'd0;
            Tx_Start_Sig   <= 1'b0;
            Tx_Data        <= 8'h00;
            Frame_Done_Sig <= 1'b0;
            Err_Sig        <= 1'b0;
        end else begin
            state          <= state_nxt;
            type_reg       <= type_nxt;
            count          <= count_nxt;
            csum           <= csum_nxt;
            idx            <= idx_nxt;
            Tx_Start_Sig   <= tx_start_nxt;
            Tx_Data        <= tx_data_nxt;
            Frame_Done_Sig <= done_nxt;
            Err_Sig        <= err_nxt;
        end
    end

    // Payload storage; contents are only meaningful up to count, so no reset.
    always_ff @(posedge CLOCK_50M) begin
        if (buf_we) begin
            frame_buf[count[AW-1:0]] <= Data;
        end
    end

endmodule

// File: tb/tb_tx_frame_packer.sv
// Bench for tx_frame_packer: three instances (defaults, MAX_LEN=4, XOR
// checksum), directed frames with hand-computed byte streams, a UART model
// answering each Tx_Start_Sig with Tx_Done_Sig ten cycles later, and a
// monitor that pops expected bytes / done / error events from queues.
module tb_tx_frame_packer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #10 clk = ~clk;
    logic rst;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals (index 0: default, 1: MAX_LEN=4, 2: XOR) ----------------
    logic       f_start [3];
    logic [7:0] f_type  [3];
    logic       d_send  [3];
    logic [7:0] d_data  [3];
    logic       f_end   [3];
    logic       tx_done [3];
    logic       tx_start[3];
    logic [7:0] tx_data [3];
    logic       tx_en   [3];
    logic       busy    [3];
    logic       f_done  [3];
    logic       err     [3];
    logic [1:0] st      [3];

    tx_frame_packer u_def (
        .CLOCK_50M(clk), .RST(rst),
        .Frame_Start_Sig(f_start[0]), .Frame_Type(f_type[0]),
        .Data_Send_Sig(d_send[0]), .Data(d_data[0]), .Frame_End_Sig(f_end[0]),
        .Tx_Done_Sig(tx_done[0]), .Tx_Start_Sig(tx_start[0]), .Tx_Data(tx_data[0]),
        .Tx_En_Sig(tx_en[0]), .Busy(busy[0]), .Frame_Done_Sig(f_done[0]),
        .Err_Sig(err[0]), .state_dbg(st[0])
    );

    tx_frame_packer #(.MAX_LEN(4)) u_len4 (
        .CLOCK_50M(clk), .RST(rst),
        .Frame_Start_Sig(f_start[1]), .Frame_Type(f_type[1]),
        .Data_Send_Sig(d_send[1]), .Data(d_data[1]), .Frame_End_Sig(f_end[1]),
        .Tx_Done_Sig(tx_done[1]), .Tx_Start_Sig(tx_start[1]), .Tx_Data(tx_data[1]),
        .Tx_En_Sig(tx_en[1]), .Busy(busy[1]), .Frame_Done_Sig(f_done[1]),
        .Err_Sig(err[1]), .state_dbg(st[1])
    );

    tx_frame_packer #(.CSUM_MODE(1)) u_xor (
        .CLOCK_50M(clk), .RST(rst),
        .Frame_Start_Sig(f_start[2]), .Frame_Type(f_type[2]),
        .Data_Send_Sig(d_send[2]), .Data(d_data[2]), .Frame_End_Sig(f_end[2]),
        .Tx_Done_Sig(tx_done[2]), .Tx_Start_Sig(tx_start[2]), .Tx_Data(tx_data[2]),
        .Tx_En_Sig(tx_en[2]), .Busy(busy[2]), .Frame_Done_Sig(f_done[2]),
        .Err_Sig(err[2]), .state_dbg(st[2])
    );

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];   // {dut, byte}
    int         done_q[$];  // dut expected to pulse Frame_Done_Sig
    int         err_q[$];   // dut expected to pulse Err_Sig
    logic [7:0] fr[$];
    int         trig[3];        // cycle of the last closing strobe / Tx_Done_Sig
    int         uart_cnt[3];
    int         uart_budget[3];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor + UART model ----------------
    initial begin
        for (int d = 0; d < 3; d++) begin
            tx_done[d]  = 1'b0;
            uart_cnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (tx_start[d] === 1'b1) begin
                    check("start_timing", cyc, trig[d] + 1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_byte: dut %0d sent %h, nothing expected", d, tx_data[d]);
                    end else begin
                        check("tx_byte", {22'd0, d[1:0], tx_data[d]}, {22'd0, exp_q.pop_front()});
                    end
                    uart_cnt[d] = 10;
                end
                if (f_done[d] === 1'b1) begin
                    check("done_timing", cyc, trig[d] + 1);
                    if (done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_done: dut %0d pulsed, not expected", d);
                    end else begin
                        check("frame_done_dut", d, done_q.pop_front());
                    end
                end
                if (err[d] === 1'b1) begin
                    if (err_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL err_sig: dut %0d pulsed, not expected", d);
                    end else begin
                        check("err_dut", d, err_q.pop_front());
                    end
                end
                if (tx_done[d]) begin
                    tx_done[d] = 1'b0;
                end else if (uart_cnt[d] > 0) begin
                    uart_cnt[d]--;
                    if (uart_cnt[d] == 0 && uart_budget[d] > 0) begin
                        tx_done[d] = 1'b1;
                        trig[d] = cyc;
                        uart_budget[d]--;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse(input int d, input logic s, input logic [7:0] ty, input logic ds,
                         input logic [7:0] dv, input logic fe, input logic closes);
        @(negedge clk);
        f_start[d] = s;
        f_type[d]  = ty;
        d_send[d]  = ds;
        d_data[d]  = dv;
        f_end[d]   = fe;
        if (closes) trig[d] = cyc;
        @(negedge clk);
        f_start[d] = 1'b0;
        d_send[d]  = 1'b0;
        f_end[d]   = 1'b0;
    endtask

    task automatic start(input int d, input logic [7:0] ty);
        pulse(d, 1'b1, ty, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input int d, input logic [7:0] v, input logic closes);
        pulse(d, 1'b0, 8'h00, 1'b1, v, 1'b0, closes);
    endtask

    task automatic send_end(input int d, input logic [7:0] v);
        pulse(d, 1'b0, 8'h00, 1'b1, v, 1'b1, 1'b1);
    endtask

    task automatic end_frame(input int d);
        pulse(d, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic expect_bytes(input int d);
        foreach (fr[i]) exp_q.push_back({d[1:0], fr[i]});
    endtask

    task automatic expect_frame(input int d);
        expect_bytes(d);
        done_q.push_back(d);
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit && (exp_q.size() + done_q.size() + err_q.size()) != 0; i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        check(name, exp_q.size() + done_q.size() + err_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_tx_start", tx_start[d], 0);
        check("rst_tx_data", tx_data[d], 0);
        check("rst_tx_en", tx_en[d], 0);
        check("rst_busy", busy[d], 0);
        check("rst_frame_done", f_done[d], 0);
        check("rst_err", err[d], 0);
        check("rst_state", st[d], 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            f_start[d] = 1'b0; f_type[d] = 8'h00; d_send[d] = 1'b0;
            d_data[d]  = 8'h00; f_end[d] = 1'b0;
            trig[d] = 0; uart_budget[d] = 1000;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_reset_outputs(d);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Strobes with no open frame are rejected.
        err_q.push_back(0);
        send(0, 8'h55, 1'b0);
        err_q.push_back(0);
        pulse(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_drain("idle_err_drain", 20);

        // Basic frame: type 01, bytes 11 22 33 44, then end pulse.
        fr = '{8'hFF, 8'hFE, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'hAA, 8'hFE, 8'hFF};
        start(0, 8'h01);
        check("collect_busy", busy[0], 1);
        check("collect_tx_en", tx_en[0], 0);
        check("collect_state", st[0], 1);
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        send(0, 8'h33, 1'b0);
        send(0, 8'h44, 1'b0);
        expect_frame(0);
        end_frame(0);
        check("send_tx_en", tx_en[0], 1);
        check("send_state", st[0], 2);
        wait_drain("basic_drain", 400);
        check("after_busy", busy[0], 0);

        // Restart mid-collect, then end coincident with the last byte.
        fr = '{8'hFF, 8'hFE, 8'h20, 8'h02, 8'h05, 8'h06, 8'h00, 8'h0B, 8'hFE, 8'hFF};
        start(0, 8'h10);
        send(0, 8'hAB, 1'b0);
        send(0, 8'hCD, 1'b0);
        start(0, 8'h20);
        send(0, 8'h05, 1'b0);
        expect_frame(0);
        send_end(0, 8'h06);
        wait_drain("restart_drain", 400);

        // Empty frame.
        fr = '{8'hFF, 8'hFE, 8'h5A, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF};
        start(0, 8'h5A);
        expect_frame(0);
        end_frame(0);
        wait_drain("empty_drain", 300);

        // Sixteen FF bytes: auto-close at MAX_LEN, sum wraps to 0FF0.
        fr = '{8'hFF, 8'hFE, 8'h33, 8'h10};
        for (int i = 0; i < 16; i++) fr.push_back(8'hFF);
        fr.push_back(8'h0F); fr.push_back(8'hF0); fr.push_back(8'hFE); fr.push_back(8'hFF);
        start(0, 8'h33);
        expect_frame(0);
        for (int i = 0; i < 16; i++) send(0, 8'hFF, (i == 15));
        wait_drain("full_drain", 600);

        // XOR checksum: 0F ^ F0 ^ FF = 00.
        fr = '{8'hFF, 8'hFE, 8'h07, 8'h03, 8'h0F, 8'hF0, 8'hFF, 8'h00, 8'h00, 8'hFE, 8'hFF};
        start(2, 8'h07);
        send(2, 8'h0F, 1'b0);
        send(2, 8'hF0, 1'b0);
        expect_frame(2);
        send_end(2, 8'hFF);
        wait_drain("xor_drain", 400);

        // MAX_LEN=4: fourth byte closes, fifth strobe lands in SEND.
        fr = '{8'hFF, 8'hFE, 8'h44, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h0A, 8'hFE, 8'hFF};
        start(1, 8'h44);
        send(1, 8'h01, 1'b0);
        send(1, 8'h02, 1'b0);
        send(1, 8'h03, 1'b0);
        expect_frame(1);
        send(1, 8'h04, 1'b1);
        err_q.push_back(1);
        send(1, 8'h05, 1'b0);
        wait_drain("maxlen_drain", 400);

        // Reset after the third Tx_Done_Sig: four bytes out, then silence.
        uart_budget[0] = 3;
        fr = '{8'hFF, 8'hFE, 8'h77, 8'h01};
        expect_bytes(0);
        start(0, 8'h77);
        send(0, 8'h9A, 1'b0);
        end_frame(0);
        wait_drain("abort_bytes_drain", 200);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        uart_budget[0] = 1000;

        // The next frame after the abort goes out intact.
        fr = '{8'hFF, 8'hFE, 8'h78, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFE, 8'hFF};
        start(0, 8'h78);
        send(0, 8'h01, 1'b0);
        expect_frame(0);
        end_frame(0);
        wait_drain("post_abort_drain", 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
